// File: rtl/lcd_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// lcd_cmd_sequencer_if
// Bundles the two buses of the LCD command sequencer:
//   - table lookup: tbl_idx (sequencer -> table), tbl_word (table -> sequencer,
//     combinational on tbl_idx)
//   - command handshake: cmd_valid/cmd_word (sequencer -> driver),
//     cmd_ready (driver -> sequencer)
// Modports:
//   master : the sequencer side
//   slave  : the table/driver side
// ---------------------------------------------------------------------------
interface lcd_cmd_sequencer_if #(
  parameter int CMD_W  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);

  logic [ADDR_W-1:0]       tbl_idx;
  logic [CMD_W+DATA_W-1:0] tbl_word;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [CMD_W+DATA_W-1:0] cmd_word;

  modport master (
    output tbl_idx,
    output cmd_valid,
    output cmd_word,
    input  tbl_word,
    input  cmd_ready
  );

  modport slave (
    input  tbl_idx,
    input  cmd_valid,
    input  cmd_word,
    output tbl_word,
    output cmd_ready
  );

endinterface

// File: rtl/lcd_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// lcd_cmd_sequencer
// Walks a combinational LCD command table from index 0 to SEQ_LEN-1 and
// hands every non-wait entry to the LCD driver over valid/ready. Entries whose
// opcode is OP_WAIT are consumed internally as a delay of
// (data+1)*WAIT_UNIT clock cycles. At the end of the table the sequencer
// either wraps to index 0 (loop_en=1) or pulses done and returns to idle.
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start            level, only sampled while idle
//   abort            synchronous return to idle, highest priority
//   loop_en          sampled when the last entry retires
//   bus (master)     tbl_idx/tbl_word table lookup, cmd_valid/cmd_ready/cmd_word
//   busy             high in every state except idle
//   done             one-cycle pulse at the end of a one-shot sequence
// ---------------------------------------------------------------------------
module lcd_cmd_sequencer #(
  parameter int              CMD_W     = 4,
  parameter int              DATA_W    = 8,
  parameter int              ADDR_W    = 5,
  parameter int              SEQ_LEN   = 22,
  parameter int              WAIT_UNIT = 1000,
  parameter logic [CMD_W-1:0] OP_WAIT  = 4'b0100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                loop_en,
  lcd_cmd_sequencer_if.master bus,
  output logic                busy,
  output logic                done
);

  // Largest delay is 2**DATA_W * WAIT_UNIT cycles, so the loaded value
  // (delay - 1) always fits in CNT_W bits.
  localparam int CNT_W = $clog2((2 ** DATA_W) * WAIT_UNIT);
  localparam int CW1   = CNT_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SEQ_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                  state;
  logic [ADDR_W-1:0]       idx;
  logic [CMD_W+DATA_W-1:0] word;
  logic                    valid;
  logic [CNT_W-1:0]        cnt;

  logic [CMD_W-1:0]        fetch_op;
  logic [DATA_W-1:0]       fetch_data;
  logic                    at_last;
  logic                    advance;

  // Counter preload for a wait entry. Computed one bit wider than the
  // counter so the intermediate product never wraps.
  function automatic logic [CNT_W-1:0] wait_load(input logic [DATA_W-1:0] d);
    logic [CW1-1:0] ticks;
    ticks = (CW1'(d) + CW1'(1)) * CW1'(WAIT_UNIT) - CW1'(1);
    return ticks[CNT_W-1:0];
  endfunction

  always_comb begin
    fetch_op   = bus.tbl_word[CMD_W+DATA_W-1 -: CMD_W];
    fetch_data = bus.tbl_word[DATA_W-1:0];
    at_last    = (idx == LAST_IDX);
    // The current entry retires either on its handshake or when its delay ends.
    advance    = ((state == S_ISSUE) && valid && bus.cmd_ready) ||
                 ((state == S_WAIT) && (cnt == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      word  <= '0;
      valid <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Drops valid even mid-handshake; the driver tolerates this.
        state <= S_IDLE;
        idx   <= '0;
        valid <= 1'b0;
        cnt   <= '0;
        busy  <= 1'b0;
      end else if (advance) begin
        valid <= 1'b0;
        if (!at_last) begin
          idx   <= idx + ADDR_W'(1);
          state <= S_FETCH;
        end else if (loop_en) begin
          idx   <= '0;
          state <= S_FETCH;
        end else begin
          state <= S_DONE;
          done  <= 1'b1;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state <= S_FETCH;
              busy  <= 1'b1;
            end
          end
          S_FETCH: begin
            word <= bus.tbl_word;
            if (fetch_op == OP_WAIT) begin
              state <= S_WAIT;
              cnt   <= wait_load(fetch_data);
            end else begin
              state <= S_ISSUE;
              valid <= 1'b1;
            end
          end
          S_ISSUE: begin
            // Hold cmd_word/cmd_valid until the driver takes it.
          end
          S_WAIT: begin
            cnt <= cnt - CNT_W'(1);
          end
          S_DONE: begin
            state <= S_IDLE;
            idx   <= '0;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            idx   <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.tbl_idx   = idx;
  assign bus.cmd_valid = valid;
  assign bus.cmd_word  = word;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lcd_cmd_sequencer
// Bench for lcd_cmd_sequencer (SEQ_LEN=22, WAIT_UNIT=4). A timing model
// tracks the current entry and the number of edges until it either becomes
// valid or (for a wait entry) retires; it is compared with the DUT on every
// falling edge. Directed runs pin the model with hand-computed values, then
// randomized tables and ready patterns are checked against the in-order list
// of non-wait table entries.
// ---------------------------------------------------------------------------
module tb_lcd_cmd_sequencer;

  localparam int CMD_W   = 4;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 5;
  localparam int SEQ_LEN = 22;
  localparam int WU      = 4;
  localparam logic [3:0] OPW = 4'b0100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic loop_en = 1'b0;
  logic ready = 1'b1;
  logic busy;
  logic done;
  logic [11:0] tbl [0:31];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit rnd_ready = 1'b0;

  lcd_cmd_sequencer_if #(.CMD_W(CMD_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  assign bus.tbl_word  = tbl[bus.tbl_idx];
  assign bus.cmd_ready = ready;

  lcd_cmd_sequencer #(
    .CMD_W(CMD_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .SEQ_LEN(SEQ_LEN), .WAIT_UNIT(WU), .OP_WAIT(OPW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .loop_en(loop_en),
    .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  bit m_valid = 1'b0;
  int m_idx = 0;
  int m_cd = 0;
  logic [11:0] m_word = '0;

  function automatic bit is_wait(input int i);
    return tbl[i][11:8] == OPW;
  endfunction

  // Edges from presenting entry i until it is valid (1) or retires (wait).
  function automatic int cost(input int i);
    if (is_wait(i)) return 1 + (int'(tbl[i][7:0]) + 1) * WU;
    return 1;
  endfunction

  task automatic m_advance();
    if (m_idx < SEQ_LEN - 1) begin
      m_idx = m_idx + 1;
      m_cd  = cost(m_idx);
    end else if (loop_en) begin
      m_idx = 0;
      m_cd  = cost(0);
    end else begin
      m_done = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_valid = 1'b0; m_idx = 0; m_cd = 0;
    end else if (abort) begin
      m_busy = 1'b0; m_done = 1'b0; m_valid = 1'b0; m_idx = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1; m_idx = 0; m_cd = cost(0);
      end
    end else if (m_done) begin
      m_done = 1'b0; m_busy = 1'b0; m_idx = 0;
    end else if (m_valid) begin
      if (ready) begin
        m_valid = 1'b0;
        m_advance();
      end
    end else begin
      m_cd = m_cd - 1;
      if (m_cd == 0) begin
        if (is_wait(m_idx)) m_advance();
        else begin
          m_valid = 1'b1;
          m_word  = tbl[m_idx];
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [11:0] hs_word[$];
  int hs_cyc[$];
  int done_cnt = 0;
  int done_cyc = -1;
  int vis [0:31];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && bus.cmd_valid && bus.cmd_ready) begin
      hs_word.push_back(bus.cmd_word);
      hs_cyc.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("cmd_valid", 32'(bus.cmd_valid), 32'(m_valid));
      chk("tbl_idx", 32'(bus.tbl_idx), 32'(m_idx));
      if (m_valid) chk("cmd_word", 32'(bus.cmd_word), 32'(m_word));
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) vis[bus.tbl_idx]++;
    end
  end

  function automatic logic [31:0] hs_at(input int k);
    if (k < 0 || k >= hs_word.size()) return 32'hDEAD_BEEF;
    return 32'(hs_word[k]);
  endfunction

  function automatic int hc_at(input int k);
    if (k < 0 || k >= hs_cyc.size()) return -1000;
    return hs_cyc[k];
  endfunction

  task automatic clear_logs();
    hs_word.delete();
    hs_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
    for (int i = 0; i < 32; i++) vis[i] = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    if (rnd_ready) ready = ($urandom_range(0, 3) != 0);
  endtask

  // kind 0: idx==val & !valid, 1: idx==val & valid, 2: done, 3: !busy
  task automatic wait_for(input int kind, input int val, input int budget, input string name);
    int n;
    bit hit;
    n = 0;
    while (1) begin
      case (kind)
        0:       hit = (int'(bus.tbl_idx) == val) && !bus.cmd_valid;
        1:       hit = (int'(bus.tbl_idx) == val) && bus.cmd_valid;
        2:       hit = done;
        default: hit = !busy;
      endcase
      if (hit) return;
      if (n >= budget) begin
        n_chk++;
        n_fail++;
        $display("FAIL timeout %s: condition not reached within %0d cycles", name, budget);
        return;
      end
      tick();
      n++;
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic build_fixed();
    tbl[0] = 12'h304;
    tbl[1] = 12'h157;
    for (int i = 2; i < 20; i++)
      tbl[i] = {((i % 2) != 0) ? 4'b0001 : 4'b0011, 8'(i * 7 + 1)};
    tbl[20] = 12'h400;
    tbl[21] = 12'h000;
    for (int i = 22; i < 32; i++) tbl[i] = 12'hFFF;
  endtask

  task automatic build_random();
    logic [3:0] op;
    int r;
    for (int i = 0; i < 32; i++) begin
      r = $urandom_range(0, 5);
      op = (r == 0) ? OPW : (r == 1) ? 4'b0011 : (r == 2) ? 4'b0000 : 4'($urandom_range(0, 15));
      tbl[i] = {op, (op == OPW) ? 8'($urandom_range(0, 3)) : 8'($urandom)};
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic [11:0] exp_q[$];

    build_fixed();
    clear_logs();
    repeat (3) tick();
    rst_n = 1'b1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(bus.cmd_valid), 32'd0);
    chk("reset_idx", 32'(bus.tbl_idx), 32'd0);
    chk("reset_word", 32'(bus.cmd_word), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    tick();

    // One-shot run, ready tied high
    clear_logs();
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!bus.cmd_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("start_latency", 32'(lat), 32'd2);
    wait_for(2, 0, 500, "oneshot_done");
    tick();
    chk("oneshot_hs_count", 32'(hs_word.size()), 32'd21);
    chk("oneshot_hs0", hs_at(0), 32'h304);
    chk("oneshot_hs1", hs_at(1), 32'h157);
    chk("oneshot_hs_last", hs_at(20), 32'h000);
    chk("oneshot_gap_plain", 32'(hc_at(1) - hc_at(0)), 32'd2);
    chk("oneshot_gap_wait0", 32'(hc_at(20) - hc_at(19)), 32'd7);
    chk("oneshot_wait0_cycles", 32'(vis[20]), 32'd5);
    chk("oneshot_done_count", 32'(done_cnt), 32'd1);
    chk("oneshot_done_time", 32'(done_cyc - hc_at(20)), 32'd1);

    // Backpressure on entry 1, plus a {wait,2} entry at index 5
    tbl[5] = 12'h402;
    clear_logs();
    start_pulse();
    wait_for(0, 1, 20, "bp_fetch1");
    ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(bus.cmd_valid), 32'd1);
      chk("bp_word", 32'(bus.cmd_word), 32'h157);
      chk("bp_idx", 32'(bus.tbl_idx), 32'd1);
      if (k < 4) tick();
    end
    ready = 1'b1;
    tick();
    chk("bp_idx_after", 32'(bus.tbl_idx), 32'd2);
    rnd_ready = 1'b1;
    wait_for(2, 0, 3000, "bp_done");
    tick();
    rnd_ready = 1'b0;
    ready = 1'b1;
    chk("bp_hs_count", 32'(hs_word.size()), 32'd20);
    chk("bp_hs1", hs_at(1), 32'h157);
    chk("wait2_cycles", 32'(vis[5]), 32'd13);
    chk("bp_done_count", 32'(done_cnt), 32'd1);
    tbl[5] = {4'b0001, 8'(5 * 7 + 1)};

    // Loop mode
    clear_logs();
    rnd_ready = 1'b1;
    loop_en = 1'b1;
    start_pulse();
    wait_for(0, 21, 3000, "loop_last");
    wait_for(0, 0, 3000, "loop_wrap");
    chk("loop_no_done", 32'(done_cnt), 32'd0);
    chk("loop_busy", 32'(busy), 32'd1);
    wait_for(0, 1, 3000, "loop_second_pass");
    loop_en = 1'b0;
    wait_for(2, 0, 3000, "loop_done");
    tick();
    rnd_ready = 1'b0;
    ready = 1'b1;
    chk("loop_hs_count", 32'(hs_word.size()), 32'd42);
    chk("loop_done_count", 32'(done_cnt), 32'd1);
    chk("loop_hs_last", hs_at(41), 32'h000);

    // Abort during WAIT, then during ISSUE with a same-cycle handshake
    clear_logs();
    start_pulse();
    wait_for(0, 20, 500, "abort_reach_wait");
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_wait_busy", 32'(busy), 32'd0);
    chk("abort_wait_valid", 32'(bus.cmd_valid), 32'd0);
    chk("abort_wait_idx", 32'(bus.tbl_idx), 32'd0);
    chk("abort_wait_done", 32'(done), 32'd0);
    clear_logs();
    start_pulse();
    wait_for(1, 3, 100, "abort_reach_issue");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_issue_busy", 32'(busy), 32'd0);
    chk("abort_issue_valid", 32'(bus.cmd_valid), 32'd0);
    chk("abort_issue_idx", 32'(bus.tbl_idx), 32'd0);
    chk("abort_issue_hs", 32'(hs_word.size()), 32'd4);
    clear_logs();
    start_pulse();
    wait_for(2, 0, 500, "replay_done");
    tick();
    chk("replay_hs0", hs_at(0), 32'h304);
    chk("replay_hs_count", 32'(hs_word.size()), 32'd21);
    chk("replay_done_count", 32'(done_cnt), 32'd1);

    // Reset in the middle of ISSUE
    clear_logs();
    ready = 1'b0;
    start_pulse();
    wait_for(1, 0, 20, "rst_reach_issue");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(bus.cmd_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_idx", 32'(bus.tbl_idx), 32'd0);
    chk("rst_mid_word", 32'(bus.cmd_word), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (3) tick();
    chk("rst_mid_idle", 32'(busy), 32'd0);
    chk("rst_mid_no_done", 32'(done_cnt), 32'd0);

    // Randomized tables and ready patterns
    for (int r = 0; r < 6; r++) begin
      build_random();
      if (r == 0) tbl[21] = {OPW, 8'd1};
      exp_q.delete();
      for (int i = 0; i < SEQ_LEN; i++)
        if (tbl[i][11:8] != OPW) exp_q.push_back(tbl[i]);
      rnd_ready = (r != 1);
      ready = 1'b1;
      clear_logs();
      if (r == 2) begin
        start = 1'b1;
        wait_for(2, 0, 5000, "relaunch_first_done");
        tick();
        chk("relaunch_idle", 32'(busy), 32'd0);
        tick();
        chk("relaunch_busy", 32'(busy), 32'd1);
        start = 1'b0;
        clear_logs();
      end else begin
        start_pulse();
      end
      wait_for(2, 0, 5000, "rand_done");
      tick();
      chk("rand_hs_count", 32'(hs_word.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++)
        chk("rand_hs_word", hs_at(k), 32'(exp_q[k]));
      chk("rand_done_count", 32'(done_cnt), 32'd1);
    end
    rnd_ready = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
